// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM encoding,
// default buffer depth, default reset PC and the sequential-PC helper.
package mips_fetch_pkg;

    // Fetch controller states. Memory request is asserted in WAIT and DISCARD.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    localparam int          DEFAULT_DEPTH    = 2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    // Next sequential instruction address; 16-bit wrap (FFFE -> 0000).
    function automatic logic [15:0] pc_seq_next(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x 32-bit circular FIFO with push, pop and flush.
// Entry layout: [31:16] = address of instruction + 2, [15:0] = instruction.
// Flush wins over push/pop in the same cycle. The caller never pushes when
// full and never pops when empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [31:0]   head_data,
    output logic [CW-1:0] count
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    // Storage write; contents need no reset because the head is qualified by count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: issues one outstanding 16-bit instruction read
// at a time, buffers returned words in fetch_fifo and presents the head to
// IF/ID. Taken-branch redirects flush the buffer and discard any in-flight
// read. Optional performance counters are enabled by defining
// FETCH_PERF_CNT_EN.
//
// Handshakes:
//   memory side  - o_Mem_Req/o_Mem_Addr are registered and held stable until
//                  i_Mem_Ack; i_Mem_Data is valid only with i_Mem_Ack.
//   IF/ID side   - the head transfers on a cycle where o_Valid && i_Ready;
//                  while o_Valid && !i_Ready the head is held unchanged.
//                  o_Valid is forced low during a redirect cycle.
module fetch_prefetch
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_Redirect,
    input  logic [15:0] i_Redirect_Pc,
    output logic        o_Mem_Req,
    output logic [15:0] o_Mem_Addr,
    input  logic        i_Mem_Ack,
    input  logic [15:0] i_Mem_Data,
    output logic        o_Valid,
    output logic [15:0] o_Instruction,
    output logic [15:0] o_Pc_Plus_2,
    input  logic        i_Ready,
    output logic [1:0]  o_Dbg_State
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] o_Fetch_Count,
    output logic [15:0] o_Redirect_Count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [15:0]   fetch_pc;
    logic [15:0]   fetch_pc_next;
    logic [15:0]   mem_addr_next;
    logic          started;

    logic          push;
    logic          pop;
    logic          flush;
    logic [31:0]   push_data;
    logic [31:0]   head_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          has_entry;

    assign fifo_full = (fifo_count == CW'(DEPTH));
    assign has_entry = (fifo_count != '0);

    // Next-state, fetch PC and request address; redirects always take the new PC.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        mem_addr_next = o_Mem_Addr;
        push          = 1'b0;
        push_data     = {pc_seq_next(fetch_pc), i_Mem_Data};
        case (state)
            ST_IDLE: begin
                if (i_Redirect) begin
                    fetch_pc_next = i_Redirect_Pc;
                end else if (started && !fifo_full) begin
                    state_next    = ST_WAIT;
                    mem_addr_next = fetch_pc;
                end
            end
            ST_WAIT: begin
                if (i_Redirect) begin
                    fetch_pc_next = i_Redirect_Pc;
                    // A coinciding ack closes the request; otherwise its data is still owed.
                    state_next    = i_Mem_Ack ? ST_IDLE : ST_DISCARD;
                end else if (i_Mem_Ack) begin
                    push          = 1'b1;
                    fetch_pc_next = pc_seq_next(fetch_pc);
                    state_next    = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (i_Redirect) fetch_pc_next = i_Redirect_Pc;
                // The stale ack ends DISCARD even if a new redirect arrives with it,
                // since no further ack is owed for the abandoned request.
                if (i_Mem_Ack) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // IF/ID side: head is offered unless a redirect is flushing this cycle.
    always_comb begin
        o_Valid       = has_entry && !i_Redirect;
        o_Instruction = has_entry ? head_data[15:0]  : 16'h0000;
        o_Pc_Plus_2   = has_entry ? head_data[31:16] : 16'h0000;
        pop           = o_Valid && i_Ready;
        flush         = i_Redirect;
    end

    // State, fetch PC and registered memory request; 'started' delays the first
    // request by one cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            fetch_pc   <= RESET_PC;
            started    <= 1'b0;
            o_Mem_Req  <= 1'b0;
            o_Mem_Addr <= 16'h0000;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            started    <= 1'b1;
            o_Mem_Req  <= (state_next == ST_WAIT) || (state_next == ST_DISCARD);
            o_Mem_Addr <= mem_addr_next;
        end
    end

    assign o_Dbg_State = state;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .count     (fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    // Accepted-instruction and redirect counters, wrapping at 16'hFFFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_Fetch_Count    <= 16'h0000;
            o_Redirect_Count <= 16'h0000;
        end else begin
            if (pop)        o_Fetch_Count    <= o_Fetch_Count + 16'd1;
            if (i_Redirect) o_Redirect_Count <= o_Redirect_Count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a scripted memory responder, an expected
// queue of {pc_plus_2, instruction} filled when data is acked and drained on
// every IF/ID handshake, and point checks on request/valid timing.
module tb_fetch_prefetch;
  import mips_fetch_pkg::*;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        reset;
  logic        i_Redirect;
  logic [15:0] i_Redirect_Pc;
  logic        o_Mem_Req;
  logic [15:0] o_Mem_Addr;
  logic        i_Mem_Ack;
  logic [15:0] i_Mem_Data;
  logic        o_Valid;
  logic [15:0] o_Instruction;
  logic [15:0] o_Pc_Plus_2;
  logic        i_Ready;
  logic [1:0]  o_Dbg_State;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] o_Fetch_Count;
  logic [15:0] o_Redirect_Count;
`endif

  logic [31:0] exp_q[$];
  int total;
  int bad;

  fetch_prefetch #(
    .DEPTH    (2),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_Redirect    (i_Redirect),
    .i_Redirect_Pc (i_Redirect_Pc),
    .o_Mem_Req     (o_Mem_Req),
    .o_Mem_Addr    (o_Mem_Addr),
    .i_Mem_Ack     (i_Mem_Ack),
    .i_Mem_Data    (i_Mem_Data),
    .o_Valid       (o_Valid),
    .o_Instruction (o_Instruction),
    .o_Pc_Plus_2   (o_Pc_Plus_2),
    .i_Ready       (i_Ready),
    .o_Dbg_State   (o_Dbg_State)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_Fetch_Count    (o_Fetch_Count),
    .o_Redirect_Count (o_Redirect_Count)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory contents model
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard at the negedge, then advance to just after posedge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (o_Valid && i_Ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_delivery: observed=%h expected=none", {o_Pc_Plus_2, o_Instruction});
      end else begin
        e = exp_q.pop_front();
        check("deliver", {o_Pc_Plus_2, o_Instruction}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    i_Redirect    = 1'b0;
    i_Redirect_Pc = 16'h0000;
    i_Mem_Ack     = 1'b0;
    i_Mem_Data    = 16'h0000;
    i_Ready       = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_release();
    tick();
    check("req_after_edge1", 32'(o_Mem_Req), 32'd0);
    tick();
    check("req_after_edge2", 32'(o_Mem_Req), 32'd1);
    check("addr_after_edge2", 32'(o_Mem_Addr), 32'(RESET_PC));
  endtask

  task automatic wait_req(input string tag, input logic [15:0] addr);
    int n;
    n = 0;
    while (!o_Mem_Req && n < 20) begin
      tick();
      n++;
    end
    if (!o_Mem_Req) begin
      total++;
      bad++;
      $error("FAIL %s: observed=no request expected=request at %h", tag, addr);
    end else begin
      check(tag, 32'(o_Mem_Addr), 32'(addr));
    end
  endtask

  // driver: wait for request, one cycle of latency, then ack with data
  task automatic serve(input string tag, input logic [15:0] addr);
    logic [15:0] p2;
    p2 = addr + 16'd2;
    wait_req(tag, addr);
    tick();
    check({tag, "_hold"}, {15'd0, o_Mem_Req, o_Mem_Addr}, {15'd0, 1'b1, addr});
    i_Mem_Ack  = 1'b1;
    i_Mem_Data = mem_word(addr);
    exp_q.push_back({p2, mem_word(addr)});
    tick();
    i_Mem_Ack  = 1'b0;
    i_Mem_Data = 16'h0000;
  endtask

  task automatic drain(input string tag);
    tick();
    tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // reset state, with an ack that must be ignored
    do_reset();
    reset     = 1'b1;
    i_Mem_Ack = 1'b1;
    i_Mem_Data = 16'hDEAD;
    tick();
    check("rst_req", 32'(o_Mem_Req), 32'd0);
    check("rst_addr", 32'(o_Mem_Addr), 32'd0);
    check("rst_valid", 32'(o_Valid), 32'd0);
    check("rst_instr", 32'(o_Instruction), 32'd0);
    check("rst_pc2", 32'(o_Pc_Plus_2), 32'd0);
    check("rst_state", 32'(o_Dbg_State), 32'(ST_IDLE));
    i_Mem_Ack  = 1'b0;
    i_Mem_Data = 16'h0000;

    // sequential fetch after reset release
    do_reset();
    check_release();
    serve("t1_req0", 16'h0000);
    check("t1_valid_latency", 32'(o_Valid), 32'd1);
    check("t1_pc2_first", 32'(o_Pc_Plus_2), 32'h0002);
    serve("t1_req1", 16'h0002);
    serve("t1_req2", 16'h0004);
    drain("t1_drain");

    // stall with full buffer
    do_reset();
    i_Ready = 1'b0;
    check_release();
    serve("t2_req0", 16'h0000);
    serve("t2_req1", 16'h0002);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_no_req", 32'(o_Mem_Req), 32'd0);
      check("t2_head", {o_Pc_Plus_2, o_Instruction}, {16'h0002, mem_word(16'h0000)});
      check("t2_valid", 32'(o_Valid), 32'd1);
    end
    i_Ready = 1'b1;
    drain("t2_drain");
    wait_req("t2_next", 16'h0004);

    // redirect in WAIT, then a second redirect while discarding
    do_reset();
    check_release();
    i_Redirect    = 1'b1;
    i_Redirect_Pc = 16'h0020;
    exp_q.delete();
    tick();
    i_Redirect_Pc = 16'h0040;
    tick();
    i_Redirect = 1'b0;
    check("t3_discard_hold", {15'd0, o_Mem_Req, o_Mem_Addr}, {15'd0, 1'b1, 16'h0000});
    check("t3_state", 32'(o_Dbg_State), 32'(ST_DISCARD));
    i_Mem_Ack  = 1'b1;
    i_Mem_Data = 16'hBAD0;
    tick();
    i_Mem_Ack  = 1'b0;
    i_Mem_Data = 16'h0000;
    check("t3_req_drop", 32'(o_Mem_Req), 32'd0);
    check("t3_no_data", 32'(o_Valid), 32'd0);
    serve("t3_target", 16'h0040);
    check("t3_pc2", {15'd0, o_Valid, o_Pc_Plus_2}, {15'd0, 1'b1, 16'h0042});
    drain("t3_drain");

    // redirect coinciding with ack and with a ready head
    do_reset();
    i_Ready = 1'b0;
    check_release();
    serve("t4_req0", 16'h0000);
    wait_req("t4_req1", 16'h0002);
    tick();
    i_Ready       = 1'b1;
    i_Redirect    = 1'b1;
    i_Redirect_Pc = 16'h0100;
    i_Mem_Ack     = 1'b1;
    i_Mem_Data    = mem_word(16'h0002);
    exp_q.delete();
    #1;
    check("t4_valid_forced_low", 32'(o_Valid), 32'd0);
    tick();
    i_Redirect = 1'b0;
    i_Mem_Ack  = 1'b0;
    i_Mem_Data = 16'h0000;
    check("t4_empty_next", 32'(o_Valid), 32'd0);
    check("t4_req_low", 32'(o_Mem_Req), 32'd0);
    serve("t4_target", 16'h0100);
    check("t4_pc2", 32'(o_Pc_Plus_2), 32'h0102);
    drain("t4_drain");

    // PC wrap from FFFE to 0000, redirect issued in IDLE
    do_reset();
    i_Redirect    = 1'b1;
    i_Redirect_Pc = 16'hFFFE;
    tick();
    i_Redirect = 1'b0;
    check("t5_no_req_same", 32'(o_Mem_Req), 32'd0);
    serve("t5_top", 16'hFFFE);
    check("t5_pc2_wrap", 32'(o_Pc_Plus_2), 32'h0000);
    serve("t5_zero", 16'h0000);
    check("t5_pc2_next", 32'(o_Pc_Plus_2), 32'h0002);
    drain("t5_drain");

    // reset asserted while a request is outstanding
    do_reset();
    check_release();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6_req_drop", 32'(o_Mem_Req), 32'd0);
    check("t6_state", 32'(o_Dbg_State), 32'(ST_IDLE));
    check("t6_addr", 32'(o_Mem_Addr), 32'd0);
    exp_q.delete();
    i_Mem_Ack  = 1'b1;
    i_Mem_Data = 16'h5555;
    tick();
    tick();
    check("t6_ack_ignored", 32'(o_Valid), 32'd0);
    reset      = 1'b0;
    i_Mem_Ack  = 1'b0;
    i_Mem_Data = 16'h0000;
    check_release();
    serve("t6_req0", RESET_PC);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of instruction-buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_Redirect  input  1  taken-branch redirect strobe, i.e. PCSrc from EX/MEM.
REQ-006 SHALL have port i_Redirect_Pc  input  16  branch target address.
REQ-007 SHALL have port o_Mem_Req  output  1  instruction-memory read request, registered.
REQ-008 SHALL have port o_Mem_Addr  output  16  request address, registered.
REQ-009 SHALL have port i_Mem_Ack  input  1  memory returns data this cycle.
REQ-010 SHALL have port i_Mem_Data  input  16  instruction word, valid with i_Mem_Ack.
REQ-011 SHALL have port o_Valid  output  1  buffer head holds an instruction for IF/ID.
REQ-012 SHALL have port o_Instruction  output  16  head instruction.
REQ-013 SHALL have port o_Pc_Plus_2  output  16  head instruction address + 2.
REQ-014 SHALL have port i_Ready  input  1  IF/ID accepts the head; low means stall.

Function
REQ-015 SHALL implement the states IDLE, WAIT and DISCARD, with o_Mem_Req=1 exactly in WAIT and DISCARD.
REQ-016 SHALL move IDLE->WAIT when entries+0 < DEPTH and i_Redirect=0, latching o_Mem_Addr=fetch_pc.
REQ-017 SHALL hold o_Mem_Req and o_Mem_Addr stable until i_Mem_Ack, with one outstanding request at most.
REQ-018 SHALL handle i_Mem_Ack in WAIT as follows: push {fetch_pc+2, i_Mem_Data}, set fetch_pc+=2 (16-bit wrap, 16'hFFFE->16'h0000), and return to IDLE.
REQ-019 SHALL make a pushed entry visible on o_Valid in the cycle after the ack (one-cycle ack-to-valid latency).
REQ-020 SHALL pop the head when o_Valid && i_Ready, and SHALL hold o_Instruction/o_Pc_Plus_2 stable while o_Valid && !i_Ready.
REQ-021 SHALL permit a push and a pop in the same cycle, leaving the count unchanged.
REQ-022 SHALL never overflow the buffer, because no request issues unless a slot is free.
REQ-023 SHALL handle i_Redirect as follows: flush all entries, set fetch_pc=i_Redirect_Pc, and force o_Valid=0 in that cycle so that no handshake completes.
REQ-024 SHALL move to DISCARD on i_Redirect in WAIT without i_Mem_Ack, drop the next ack's data, then return to IDLE.
REQ-025 SHALL handle i_Redirect coinciding with i_Mem_Ack by dropping the data and moving to IDLE.
REQ-026 SHALL let the latest redirect win when i_Redirect occurs in DISCARD: update fetch_pc and stay in DISCARD.
REQ-027 SHALL issue the first request for the new target from IDLE no earlier than the cycle after a redirect.

Reset
REQ-028 SHALL, while reset is high, set state=IDLE, fetch_pc=RESET_PC, count=0, o_Mem_Req=0, o_Mem_Addr=0, o_Valid=0, o_Instruction=0, o_Pc_Plus_2=0.
REQ-029 SHALL abandon any outstanding request on reset assertion mid-operation, and SHALL ignore an ack during reset.
REQ-030 SHALL assert o_Mem_Req with o_Mem_Addr=RESET_PC on the second rising edge after reset deasserts.

Configuration
REQ-031 SHALL, when FETCH_PERF_CNT_EN is defined, add outputs o_Fetch_Count (16, accepted instructions) and o_Redirect_Count (16, redirects), both reset to 0 and wrapping at 16'hFFFF.
REQ-032 SHALL, without FETCH_PERF_CNT_EN, have neither port nor counter logic present, with all other behaviour identical.

Structure
REQ-033 SHALL place the state encoding, the default DEPTH and the default RESET_PC in shared package mips_fetch_pkg.
REQ-034 SHALL implement the buffer as sub-module fetch_fifo (DEPTH x 32 bits, push/pop/flush, count).

Verification
REQ-035 SHALL verify reset release: with ack one cycle after each request and i_Ready=1 -> addresses 0000,0002,0004 issued and o_Pc_Plus_2 sequence 0002,0004,0006.
REQ-036 SHALL verify stall: hold i_Ready=0 with DEPTH=2 -> exactly 2 acks accepted, o_Mem_Req stays 0 afterwards, and head=instr@0000 is held stable.
REQ-037 SHALL verify redirect during WAIT to 0040: the late ack data is discarded, the next request is at 0040, and the first o_Pc_Plus_2 is 0042.
REQ-038 SHALL verify redirect coinciding with an ack and with o_Valid&&i_Ready: no instruction is delivered that cycle and the buffer is empty the next cycle.
REQ-039 SHALL verify wrap: redirect to FFFE -> requests FFFE then 0000, and o_Pc_Plus_2 0000 then 0002.
REQ-040 SHALL verify reset asserted in WAIT: o_Mem_Req drops immediately, and after release the first request is at RESET_PC.
